linear_layer_start_fifo_ctrl: RTL and testbench

LINEAR_LAYER_START_FIFO_CTRL -- requirements
Module: linear_layer_start_fifo_ctrl

---
 rtl/linear_layer_fifo_pkg.sv | 15 +
 rtl/linear_layer_start_fifo_ctrl_srl.sv | 38 +++
 rtl/linear_layer_start_fifo_ctrl.sv | 85 ++++++++
 tb/tb_linear_layer_start_fifo_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/linear_layer_fifo_pkg.sv
// Shared constants for the linear-layer FIFO controllers.
//   fifo_cnt_w()   : occupancy counter width for a given read-address width
//   FULL_N_RST     : if_full_n value out of reset (space available)
//   EMPTY_N_RST    : if_empty_n value out of reset (nothing stored)
package linear_layer_fifo_pkg;

    localparam logic FULL_N_RST  = 1'b1;
    localparam logic EMPTY_N_RST = 1'b0;

    // One extra bit so the counter can hold DEPTH == 2**addr_w.
    function automatic int fifo_cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/linear_layer_start_fifo_ctrl_srl.sv
// start_fifo_srl: clocked shift-register store for the start FIFO.
//   clk  : clock
//   we   : shift din into slot 0, older entries move up one slot
//   addr : read slot (0 = newest)
//   din  : token to store
//   dout : combinational read of slot addr
// Contents are never reset; the controller's count decides what is valid.
module start_fifo_srl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                mem[i] <= mem[i-1];
        end
    end

    // Explicit mux keeps the index width independent of DEPTH.
    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++)
            if (addr == ADDR_WIDTH'(i))
                dout = mem[i];
    end

endmodule

// File: rtl/linear_layer_start_fifo_ctrl.sv
// linear_layer_start_fifo_ctrl: first-word-fall-through FIFO built on a
// shift-register store. Holds count, flags and handshake logic.
//   clk, reset        : clock, synchronous active-high reset
//   if_write_ce/write : producer enable / request, if_din token in
//   if_full_n         : registered, 1 while space is available
//   if_read_ce/read   : consumer enable / request
//   if_dout           : oldest stored token (don't-care while empty)
//   if_empty_n        : registered, 1 while data is available
//   if_num_data_valid : registered count, only with START_FIFO_OCCUPANCY_EN
module linear_layer_start_fifo_ctrl
    import linear_layer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
`ifdef START_FIFO_OCCUPANCY_EN
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
`endif
    output logic                  if_empty_n
);

    localparam int                CW      = fifo_cnt_w(ADDR_WIDTH);
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]         count, count_nxt;
    logic                  push, pop;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Handshakes use the registered flags, so a full FIFO refuses a write
    // even when a pop happens in the same cycle (and likewise when empty).
    assign push = if_write & if_write_ce & if_full_n;
    assign pop  = if_read  & if_read_ce  & if_empty_n;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            if_full_n  <= FULL_N_RST;
            if_empty_n <= EMPTY_N_RST;
        end else begin
            count      <= count_nxt;
            if_full_n  <= (count_nxt != DEPTH_C);
            if_empty_n <= (count_nxt != '0);
        end
    end

    // Newest token sits in slot 0, so the oldest is at count-1.
    logic [CW-1:0] count_m1;
    assign count_m1 = count - 1'b1;
    assign rd_addr  = (count == '0) ? '0 : count_m1[ADDR_WIDTH-1:0];

    start_fifo_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk  (clk),
        .we   (push),
        .addr (rd_addr),
        .din  (if_din),
        .dout (if_dout)
    );

`ifdef START_FIFO_OCCUPANCY_EN
    assign if_num_data_valid = count;
`endif

endmodule

// File: tb/tb_linear_layer_start_fifo_ctrl.sv
module tb_linear_layer_start_fifo_ctrl;

    localparam int DW = 4;
    localparam int AW = 1;
    localparam int DP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write_ce, if_write, if_read_ce, if_read;
    logic [DW-1:0] if_din;
    logic [DW-1:0] if_dout;
    logic          if_full_n, if_empty_n;
`ifdef START_FIFO_OCCUPANCY_EN
    logic [AW:0]   if_num_data_valid;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    linear_layer_start_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DP)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .if_write_ce       (if_write_ce),
        .if_write          (if_write),
        .if_din            (if_din),
        .if_full_n         (if_full_n),
        .if_read_ce        (if_read_ce),
        .if_read           (if_read),
        .if_dout           (if_dout),
`ifdef START_FIFO_OCCUPANCY_EN
        .if_num_data_valid (if_num_data_valid),
`endif
        .if_empty_n        (if_empty_n)
    );

    // Inputs change 1 time unit after a rising edge; outputs sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
        if_write = w;
        if_din   = d;
        if_read  = r;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0);
        if_write_ce = 1'b1;
        if_read_ce  = 1'b1;
    endtask

    task automatic chk_flags(input string nm, input logic fn, input logic en);
        n_cmp++;
        if (if_full_n !== fn) begin
            n_err++;
            $display("FAIL %s full_n got %b want %b", nm, if_full_n, fn);
        end
        n_cmp++;
        if (if_empty_n !== en) begin
            n_err++;
            $display("FAIL %s empty_n got %b want %b", nm, if_empty_n, en);
        end
    endtask

    task automatic chk_dout(input string nm, input logic [DW-1:0] d);
        n_cmp++;
        if (if_dout !== d) begin
            n_err++;
            $display("FAIL %s dout got %h want %h", nm, if_dout, d);
        end
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        chk_flags("reset", 1'b1, 1'b0);
    endtask

    task automatic test_fill();
        drive(1'b1, 4'hA, 1'b0); step();
        chk_flags("fill1", 1'b1, 1'b1);
        chk_dout("fill1", 4'hA);
        drive(1'b1, 4'hB, 1'b0); step();
        chk_flags("fill2", 1'b0, 1'b1);
        chk_dout("fill2", 4'hA);
        drive(1'b1, 4'hC, 1'b0); step();
        chk_flags("fill3_drop", 1'b0, 1'b1);
        chk_dout("fill3_drop", 4'hA);
        idle();
    endtask

    task automatic test_drain();
        drive(1'b0, '0, 1'b1); step();
        chk_flags("drain1", 1'b1, 1'b1);
        chk_dout("drain1", 4'hB);
        step();
        chk_flags("drain2", 1'b1, 1'b0);
        step();
        chk_flags("drain3_ignored", 1'b1, 1'b0);
        // A fresh write must surface itself, not the dropped 0xC.
        drive(1'b1, 4'h5, 1'b0); step();
        chk_flags("after_drain_w", 1'b1, 1'b1);
        chk_dout("after_drain_w", 4'h5);
        drive(1'b0, '0, 1'b1); step();
        chk_flags("after_drain_r", 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_simul();
        drive(1'b1, 4'h1, 1'b0); step();
        chk_dout("simul_pre", 4'h1);
        drive(1'b1, 4'h2, 1'b1); step();
        chk_flags("simul", 1'b1, 1'b1);
        chk_dout("simul", 4'h2);
        drive(1'b0, '0, 1'b1); step();
        chk_flags("simul_cnt1", 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_ce_gate();
        drive(1'b1, 4'h3, 1'b0);
        if_write_ce = 1'b0;
        step();
        chk_flags("wce_gate", 1'b1, 1'b0);
        if_write_ce = 1'b1;
        drive(1'b1, 4'h7, 1'b0); step();
        drive(1'b0, '0, 1'b1);
        if_read_ce = 1'b0;
        step();
        chk_flags("rce_gate", 1'b1, 1'b1);
        chk_dout("rce_gate", 4'h7);
        if_read_ce = 1'b1;
        step();
        chk_flags("rce_pop", 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_full_write_pop();
        drive(1'b1, 4'h3, 1'b0); step();
        drive(1'b1, 4'h4, 1'b0); step();
        chk_flags("full_pre", 1'b0, 1'b1);
        drive(1'b1, 4'h5, 1'b1); step();
        chk_flags("full_wr_pop", 1'b1, 1'b1);
        chk_dout("full_wr_pop", 4'h4);
        drive(1'b0, '0, 1'b1); step();
        chk_flags("full_wr_pop_cnt", 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_empty_read_push();
        drive(1'b1, 4'h6, 1'b1); step();
        chk_flags("empty_rd_push", 1'b1, 1'b1);
        chk_dout("empty_rd_push", 4'h6);
        idle();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'h8, 1'b0); step();
        chk_flags("rst_mid_pre", 1'b0, 1'b1);
        reset = 1'b1;
        drive(1'b1, 4'hE, 1'b0); step();
        reset = 1'b0;
        chk_flags("rst_mid", 1'b1, 1'b0);
        drive(1'b1, 4'h9, 1'b0); step();
        chk_flags("rst_mid_w", 1'b1, 1'b1);
        chk_dout("rst_mid_w", 4'h9);
        drive(1'b0, '0, 1'b1); step();
        chk_flags("rst_mid_r", 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] v;
        drive(1'b1, 4'h0, 1'b0); step();
        exp_q.push_back(4'h0);
        for (int i = 1; i < 8; i++) begin
            v = DW'(i);
            drive(1'b1, v, 1'b1); step();
            exp_q.push_back(v);
            void'(exp_q.pop_front());
            chk_dout("b2b", exp_q[0]);
        end
        drive(1'b0, '0, 1'b1); step();
        chk_flags("b2b_end", 1'b1, 1'b0);
        idle();
    endtask

`ifdef START_FIFO_OCCUPANCY_EN
    task automatic chk_nv(input string nm, input logic [AW:0] n);
        n_cmp++;
        if (if_num_data_valid !== n) begin
            n_err++;
            $display("FAIL %s num_data_valid got %0d want %0d", nm, if_num_data_valid, n);
        end
    endtask

    task automatic test_occupancy();
        chk_nv("occ0", 2'd0);
        drive(1'b1, 4'h1, 1'b0); step();
        chk_nv("occ1", 2'd1);
        drive(1'b1, 4'h2, 1'b0); step();
        chk_nv("occ2", 2'd2);
        drive(1'b0, '0, 1'b1); step();
        chk_nv("occ3", 2'd1);
        drive(1'b0, '0, 1'b1); step();
        idle();
    endtask
`endif

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_fill();
        test_drain();
        test_simul();
        test_ce_gate();
        test_full_write_pop();
        test_empty_read_push();
        test_reset_mid();
        test_back_to_back();
`ifdef START_FIFO_OCCUPANCY_EN
        test_occupancy();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
